// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit : program-counter stage for the pipelined RISC-V core.
//
// Produces the fetch address every cycle. The PC advances sequentially by INC,
// or jumps to a branch/jump target or to the trap vector. Every update honours
// the memory stall. A redirect that arrives during a stall is buffered and
// applied on the first unstalled edge, so no redirect is lost.
//
// Parameters
//   WIDTH         PC width in bits (at most 32)
//   RESET_VECTOR  PC loaded by reset (low WIDTH bits used)
//   TRAP_VECTOR   trap handler address (low WIDTH bits used)
//   INC           sequential increment in bytes
//
// Ports
//   CLK               clock; all state changes on posedge
//   RESET             synchronous, active-low reset
//   BUSYWAIT          memory stall; the PC holds while high
//   BRANCH_EN         branch/jump taken this cycle
//   BRANCH_TARGET     redirect target; bit 0 is forced to 0 on use
//   TRAP_EN           trap/exception redirect to TRAP_VECTOR
//   PC                current fetch address (registered)
//   PC_PLUS_INC       PC + INC modulo 2^WIDTH (combinational from PC)
//   PC_VALID          PC is a valid fetch address (registered)
//   REDIRECT_PENDING  a redirect is buffered until the stall releases
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          INC          = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             BRANCH_EN,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  input  logic             TRAP_EN,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_PLUS_INC,
  output logic             PC_VALID,
  output logic             REDIRECT_PENDING
);

  localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] TRAP_PC    = WIDTH'(TRAP_VECTOR);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  // Clears bit 0 so a redirect target is always halfword aligned.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,  // first cycle after reset; the PC is not yet valid
    RUN  = 2'd1,  // normal operation, nothing buffered
    HOLD = 2'd2   // stalled with a redirect buffered
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pc_q, pc_nx;
  logic             valid_q, valid_nx;
  logic             pending_q, pending_nx;
  logic [WIDTH-1:0] pend_tgt, pend_tgt_nx;
  logic             pend_trap, pend_trap_nx;

  logic [WIDTH-1:0] live_tgt;
  logic [WIDTH-1:0] seq_pc;

  assign live_tgt = BRANCH_TARGET & ALIGN_MASK;
  // The sum is truncated to WIDTH bits, so it wraps with no carry out.
  assign seq_pc   = pc_q + INC_W;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a hold value before the case statement. A path
    // that forgets an assignment then keeps the register value and does not
    // infer a latch.
    state_nx     = state;
    pc_nx        = pc_q;
    valid_nx     = valid_q;
    pending_nx   = pending_q;
    pend_tgt_nx  = pend_tgt;
    pend_trap_nx = pend_trap;

    case (state)
      BOOT: begin
        // Stall and redirect inputs are ignored. The PC stays at the reset
        // vector and becomes valid.
        state_nx = RUN;
        valid_nx = 1'b1;
      end

      RUN: begin
        if (!BUSYWAIT) begin
          if (TRAP_EN)        pc_nx = TRAP_PC;
          else if (BRANCH_EN) pc_nx = live_tgt;
          else                pc_nx = seq_pc;
        end else if (TRAP_EN) begin
          // A trap outranks any branch taken in the same cycle. Only the trap
          // flag is recorded.
          pend_trap_nx = 1'b1;
          pending_nx   = 1'b1;
          state_nx     = HOLD;
        end else if (BRANCH_EN) begin
          pend_tgt_nx  = live_tgt;
          pend_trap_nx = 1'b0;
          pending_nx   = 1'b1;
          state_nx     = HOLD;
        end
      end

      HOLD: begin
        if (BUSYWAIT) begin
          pending_nx = 1'b1;
          // A trap flag is sticky. A later branch only replaces the target,
          // and the most recent branch wins.
          if (TRAP_EN)   pend_trap_nx = 1'b1;
          if (BRANCH_EN) pend_tgt_nx  = live_tgt;
        end else begin
          if (TRAP_EN || pend_trap) pc_nx = TRAP_PC;
          else if (BRANCH_EN)       pc_nx = live_tgt;
          else                      pc_nx = pend_tgt;
          pending_nx   = 1'b0;
          pend_trap_nx = 1'b0;
          pend_tgt_nx  = '0;
          state_nx     = RUN;
        end
      end

      default: begin
        // An unreachable encoding recovers through BOOT, and nothing is
        // buffered on the way.
        state_nx     = BOOT;
        pc_nx        = RESET_PC;
        valid_nx     = 1'b0;
        pending_nx   = 1'b0;
        pend_tgt_nx  = '0;
        pend_trap_nx = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset is synchronous and overrides every other input,
  // including in HOLD, so a buffered redirect is discarded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make every register sample values from
    // before the edge, so the order of these statements does not matter.
    if (!RESET) begin
      state     <= BOOT;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      pend_tgt  <= '0;
      pend_trap <= 1'b0;
    end else begin
      state     <= state_nx;
      pc_q      <= pc_nx;
      valid_q   <= valid_nx;
      pending_q <= pending_nx;
      pend_tgt  <= pend_tgt_nx;
      pend_trap <= pend_trap_nx;
    end
  end

  assign PC               = pc_q;
  assign PC_PLUS_INC      = seq_pc;
  assign PC_VALID         = valid_q;
  assign REDIRECT_PENDING = pending_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit : scoreboard bench for pc_unit.
//
// The driver applies one cycle of inputs and pushes the expected post-edge
// state onto a queue. The monitor drains that queue on every falling edge and
// compares the values against the selected DUT. Three instances share the
// inputs:
//   sel 0 : default parameters
//   sel 1 : RESET_VECTOR = 0xFFFF_FFFC (32-bit wrap)
//   sel 2 : WIDTH = 16, RESET_VECTOR = 0xFFF8 (16-bit wrap)
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bw  = 1'b0;
  logic        br  = 1'b0;
  logic [31:0] tgt = '0;
  logic        trap = 1'b0;

  logic [31:0] pc0, ppi0, pc1, ppi1;
  logic [15:0] pc2, ppi2;
  logic        v0, v1, v2, p0, p1, p2;

  always #5 clk = ~clk;

  pc_unit dut0 (
    .CLK(clk), .RESET(rst), .BUSYWAIT(bw), .BRANCH_EN(br),
    .BRANCH_TARGET(tgt), .TRAP_EN(trap),
    .PC(pc0), .PC_PLUS_INC(ppi0), .PC_VALID(v0), .REDIRECT_PENDING(p0)
  );

  pc_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut1 (
    .CLK(clk), .RESET(rst), .BUSYWAIT(bw), .BRANCH_EN(br),
    .BRANCH_TARGET(tgt), .TRAP_EN(trap),
    .PC(pc1), .PC_PLUS_INC(ppi1), .PC_VALID(v1), .REDIRECT_PENDING(p1)
  );

  pc_unit #(.WIDTH(16), .RESET_VECTOR(32'h0000_FFF8)) dut2 (
    .CLK(clk), .RESET(rst), .BUSYWAIT(bw), .BRANCH_EN(br),
    .BRANCH_TARGET(tgt[15:0]), .TRAP_EN(trap),
    .PC(pc2), .PC_PLUS_INC(ppi2), .PC_VALID(v2), .REDIRECT_PENDING(p2)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] pc;
    logic [31:0] ppi;
    logic        valid;
    logic        pend;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected PC+INC is computed here from the expected PC and the DUT width.
  function automatic exp_t mk(input string name, input int sel,
                              input logic [31:0] epc, input logic evalid,
                              input logic epend);
    exp_t e;
    e.name  = name;
    e.sel   = sel;
    e.pc    = epc;
    e.ppi   = (sel == 2) ? {16'h0, epc[15:0] + 16'd4} : epc + 32'd4;
    e.valid = evalid;
    e.pend  = epend;
    return e;
  endfunction

  // Drives one cycle of inputs, waits for the edge, and pushes the expectations.
  task automatic step(input logic r, input logic b, input logic be,
                      input logic [31:0] t, input logic tr, input string name,
                      input logic [31:0] epc, input logic evalid,
                      input logic epend);
    rst = r; bw = b; br = be; tgt = t; trap = tr;
    @(posedge clk);
    q.push_back(mk(name, 0, epc, evalid, epend));
    #1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] a_pc, a_ppi;
        logic        a_v, a_p;
        e = q.pop_front();
        case (e.sel)
          1:       begin a_pc = pc1; a_ppi = ppi1; a_v = v1; a_p = p1; end
          2:       begin a_pc = {16'h0, pc2}; a_ppi = {16'h0, ppi2};
                         a_v = v2; a_p = p2; end
          default: begin a_pc = pc0; a_ppi = ppi0; a_v = v0; a_p = p0; end
        endcase
        check({e.name, ".pc"},    a_pc,         e.pc);
        check({e.name, ".ppi"},   a_ppi,        e.ppi);
        check({e.name, ".valid"}, 32'(a_v),     32'(e.valid));
        check({e.name, ".pend"},  32'(a_p),     32'(e.pend));
      end
    end
  end

  // Stimulus
  initial begin
    #1;
    // Reset and boot
    step(0, 0, 0, 32'h0,   0, "reset0",     32'h0,   0, 0);
    step(0, 0, 0, 32'h0,   0, "reset1",     32'h0,   0, 0);
    step(1, 0, 0, 32'h0,   0, "boot_exit",  32'h0,   1, 0);
    step(1, 0, 0, 32'h0,   0, "seq4",       32'h4,   1, 0);
    step(1, 0, 0, 32'h0,   0, "seq8",       32'h8,   1, 0);
    // Plain stall
    step(1, 1, 0, 32'h0,   0, "stall_a",    32'h8,   1, 0);
    step(1, 1, 0, 32'h0,   0, "stall_b",    32'h8,   1, 0);
    step(1, 1, 0, 32'h0,   0, "stall_c",    32'h8,   1, 0);
    step(1, 0, 0, 32'h0,   0, "stall_rel",  32'hC,   1, 0);
    // Unstalled redirects
    step(1, 0, 1, 32'h41,  0, "branch",     32'h40,  1, 0);
    step(1, 0, 1, 32'h41,  1, "trap_br",    32'h100, 1, 0);
    // Stalled branch
    step(1, 1, 1, 32'h200, 0, "sbr_cap",    32'h100, 1, 1);
    step(1, 1, 0, 32'h0,   0, "sbr_hold1",  32'h100, 1, 1);
    step(1, 1, 0, 32'h0,   0, "sbr_hold2",  32'h100, 1, 1);
    step(1, 0, 0, 32'h0,   0, "sbr_apply",  32'h200, 1, 0);
    // A pending trap outranks a live branch
    step(1, 1, 1, 32'h200, 0, "ptr_cap",    32'h200, 1, 1);
    step(1, 1, 0, 32'h0,   1, "ptr_trap",   32'h200, 1, 1);
    step(1, 0, 1, 32'h300, 0, "ptr_apply",  32'h100, 1, 0);
    step(1, 0, 0, 32'h0,   0, "ptr_seq",    32'h104, 1, 0);
    // Reset during HOLD discards the pending redirect; BOOT ignores inputs
    step(1, 1, 1, 32'h500, 0, "rh_cap",     32'h104, 1, 1);
    step(0, 1, 0, 32'h0,   0, "rh_reset",   32'h0,   0, 0);
    step(1, 1, 1, 32'h700, 1, "rh_boot",    32'h0,   1, 0);
    step(1, 0, 0, 32'h0,   0, "rh_nostale", 32'h4,   1, 0);
    // The latest branch wins in HOLD; the target LSB is cleared
    step(1, 1, 1, 32'h600, 0, "lw_cap",     32'h4,   1, 1);
    step(1, 1, 1, 32'h701, 0, "lw_over",    32'h4,   1, 1);
    step(1, 0, 0, 32'h0,   0, "lw_apply",   32'h700, 1, 0);
    // A live branch on release overrides a pending target
    step(1, 1, 1, 32'h800, 0, "lb_cap",     32'h700, 1, 1);
    step(1, 0, 1, 32'h901, 0, "lb_apply",   32'h900, 1, 0);

    // Wrap checks on the parameterised instances
    rst = 0; bw = 0; br = 0; tgt = '0; trap = 0;
    @(posedge clk);
    q.push_back(mk("w32_rst",  1, 32'hFFFF_FFFC, 0, 0));
    q.push_back(mk("w16_rst",  2, 32'h0000_FFF8, 0, 0));
    #1 rst = 1;
    @(posedge clk);
    q.push_back(mk("w32_boot", 1, 32'hFFFF_FFFC, 1, 0));
    q.push_back(mk("w16_boot", 2, 32'h0000_FFF8, 1, 0));
    @(posedge clk);
    q.push_back(mk("w32_wrap", 1, 32'h0000_0000, 1, 0));
    q.push_back(mk("w16_seq",  2, 32'h0000_FFFC, 1, 0));
    @(posedge clk);
    q.push_back(mk("w32_seq",  1, 32'h0000_0004, 1, 0));
    q.push_back(mk("w16_wrap", 2, 32'h0000_0000, 1, 0));
    @(posedge clk);
    q.push_back(mk("w16_seq2", 2, 32'h0000_0004, 1, 0));

    // Give the monitor a bounded window to drain the queue
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
